// File: rtl/toy_fetch_queue.sv
// toy_fetch_queue: instruction prefetcher with a small in-order queue.
// Issues one word fetch per cycle while credit allows. Captures each response
// one cycle after its request and presents the oldest entry to decode.
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   IREQ, IADDR                instruction memory request and word address
//   INSTR                      memory read data, one cycle after IREQ
//   REDIRECT, REDIRECT_ADDR    flush the queue and restart fetch at a new address
//   DEQ                        decode consumes the head entry
//   DVALID, DINSTR, DPC        head entry (DINSTR and DPC are zero when empty)
//   COUNT                      queue occupancy
module toy_fetch_queue #(
    parameter int unsigned    AW         = 30,
    parameter int unsigned    DW         = 32,
    parameter int unsigned    DEPTH      = 4,
    parameter logic [AW-1:0]  RESET_ADDR = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       IREQ,
    output logic [AW-1:0]              IADDR,
    input  logic [DW-1:0]              INSTR,
    input  logic                       REDIRECT,
    input  logic [AW-1:0]              REDIRECT_ADDR,
    input  logic                       DEQ,
    output logic                       DVALID,
    output logic [DW-1:0]              DINSTR,
    output logic [AW-1:0]              DPC,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] fpc_q, fpc_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] issue_pc_q, issue_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] pc_q   [DEPTH];

    logic ireq_c;
    logic push_c;
    logic pop_c;
    logic credit_ok_c;

    // Fetch credit: queued entries plus the outstanding response must leave a free slot.
    always_comb begin
        credit_ok_c = ({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
        ireq_c      = !RST && !REDIRECT && credit_ok_c;
        push_c      = inflight_q && !REDIRECT;
        pop_c       = DEQ && (count_q != '0) && !REDIRECT;
    end

    // Next-state: redirect flushes everything and retargets the fetch pointer.
    always_comb begin
        fpc_d      = fpc_q;
        inflight_d = ireq_c;
        issue_pc_d = issue_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (REDIRECT) begin
            fpc_d    = REDIRECT_ADDR;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (ireq_c) begin
                fpc_d      = fpc_q + AW'(1);
                issue_pc_d = fpc_q;
            end
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset also drops any outstanding response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc_q      <= RESET_ADDR;
            inflight_q <= 1'b0;
            issue_pc_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            issue_pc_q <= issue_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are only observable through the valid head.
    always_ff @(posedge CLK) begin
        if (!RST && push_c) begin
            data_q[wr_ptr_q] <= INSTR;
            pc_q[wr_ptr_q]   <= issue_pc_q;
        end
    end

    // The credit rule makes a push into a full queue impossible.
    always @(posedge CLK) begin
        if (!RST) begin
            assert (!(push_c && count_q == CW'(DEPTH)));
        end
    end

    always_comb begin
        IREQ   = ireq_c;
        IADDR  = fpc_q;
        COUNT  = count_q;
        DVALID = (count_q != '0);
        DINSTR = DVALID ? data_q[rd_ptr_q] : '0;
        DPC    = DVALID ? pc_q[rd_ptr_q]   : '0;
    end

endmodule
